bmstu_wr_arbiter: RTL

- Shares one memory write port between two requesters.
  - Source 0: SPI frame decoder write stream. It is pulse-only and cannot be stalled, so it is buffered in an internal FIFO.
  - Source 1: a local requester with a valid/ready handshake.
- Grants are issued round-robin. The selected write is registered onto a valid/ready memory bus.
- Source 0 inputs are already synchronous to clk_i; CDC from the SPI clock is done upstream.

---
 rtl/bmstu_wr_arbiter_if.sv | 48 ++++
 rtl/bmstu_wr_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bmstu_wr_arbiter_if.sv
// Bus bundle for the two-source write arbiter: source 0 write stream, source 1
// valid/ready request, memory write bus and FIFO status/control.
interface bmstu_wr_arbiter_if #(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              s0_wr_en_i;
  logic [ADDR_W-1:0] s0_wr_address_i;
  logic [DATA_W-1:0] s0_wr_data_i;

  logic              s1_valid_i;
  logic              s1_ready_o;
  logic [ADDR_W-1:0] s1_address_i;
  logic [DATA_W-1:0] s1_data_i;

  logic              mem_valid_o;
  logic              mem_ready_i;
  logic [ADDR_W-1:0] mem_address_o;
  logic [DATA_W-1:0] mem_data_o;
  logic              mem_src_o;

  logic [LVL_W-1:0]  fifo_level_o;
  logic              ovf_o;
  logic              ovf_clr_i;

  modport slave (
    input  s0_wr_en_i, s0_wr_address_i, s0_wr_data_i,
    input  s1_valid_i, s1_address_i, s1_data_i,
    output s1_ready_o,
    output mem_valid_o, mem_address_o, mem_data_o, mem_src_o,
    input  mem_ready_i,
    output fifo_level_o, ovf_o,
    input  ovf_clr_i
  );

  modport master (
    output s0_wr_en_i, s0_wr_address_i, s0_wr_data_i,
    output s1_valid_i, s1_address_i, s1_data_i,
    input  s1_ready_o,
    input  mem_valid_o, mem_address_o, mem_data_o, mem_src_o,
    output mem_ready_i,
    input  fifo_level_o, ovf_o,
    output ovf_clr_i
  );
endinterface

// File: rtl/bmstu_wr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready memory write port
// between a buffered, non-stallable stream (source 0) and a handshaked requester (source 1).
module bmstu_wr_arbiter #(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic               clk_i,
  input logic               arst,
  bmstu_wr_arbiter_if.slave bus
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              last_grant_q, last_grant_d;
  logic              mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              mem_src_q, mem_src_d;

  logic              req0_s, req1_s;
  logic              grant0_s, grant1_s;
  logic              push_s, drop_s;

  // Grant decision and memory-bus FSM; source 0 is only eligible once its entry is in the FIFO
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_src_d    = mem_src_q;
    grant0_s     = 1'b0;
    grant1_s     = 1'b0;
    req0_s       = (level_q != '0);
    req1_s       = bus.s1_valid_i;
    case (state_q)
      ST_IDLE: begin
        if (req0_s && req1_s) begin
          if (last_grant_q) begin
            grant0_s = 1'b1;
          end else begin
            grant1_s = 1'b1;
          end
        end else if (req0_s) begin
          grant0_s = 1'b1;
        end else if (req1_s) begin
          grant1_s = 1'b1;
        end else begin
          grant0_s = 1'b0;
        end
        if (grant0_s) begin
          mem_addr_d   = fifo_addr_q[rd_ptr_q];
          mem_data_d   = fifo_data_q[rd_ptr_q];
          mem_src_d    = 1'b0;
          last_grant_d = 1'b0;
          mem_valid_d  = 1'b1;
          state_d      = ST_BUSY;
        end else if (grant1_s) begin
          mem_addr_d   = bus.s1_address_i;
          mem_data_d   = bus.s1_data_i;
          mem_src_d    = 1'b1;
          last_grant_d = 1'b1;
          mem_valid_d  = 1'b1;
          state_d      = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (bus.mem_ready_i) begin
          mem_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        mem_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // FIFO pointer/level bookkeeping; a pop frees a slot for a push in the same cycle
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    push_s   = bus.s0_wr_en_i && ((level_q != FULL_LVL) || grant0_s);
    drop_s   = bus.s0_wr_en_i && !push_s;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (grant0_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, grant0_s})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Sticky overflow: a new drop wins over a simultaneous clear
  always_comb begin
    ovf_d = ovf_q;
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (bus.ovf_clr_i) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Control and output registers; last_grant resets to 1 so source 0 wins the first contention
  always_ff @(posedge clk_i or posedge arst) begin
    if (arst) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      ovf_q        <= 1'b0;
      last_grant_q <= 1'b1;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_src_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      ovf_q        <= ovf_d;
      last_grant_q <= last_grant_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_src_q    <= mem_src_d;
    end
  end

  // FIFO storage; contents are meaningless outside the pointer window so no reset is needed
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      fifo_addr_q[wr_ptr_q] <= bus.s0_wr_address_i;
      fifo_data_q[wr_ptr_q] <= bus.s0_wr_data_i;
    end
  end

  assign bus.s1_ready_o    = grant1_s & ~arst;
  assign bus.mem_valid_o   = mem_valid_q;
  assign bus.mem_address_o = mem_addr_q;
  assign bus.mem_data_o    = mem_data_q;
  assign bus.mem_src_o     = mem_src_q;
  assign bus.fifo_level_o  = level_q;
  assign bus.ovf_o         = ovf_q;
endmodule
